cache_port_arbiter: RTL and testbench
=====================================

// Module: cache_port_arbiter
// PURPOSE
//  Shares one cache slave port between two requesters (port 0, port 1) using the 4-phase
//  request/valid/evict handshake of the cache interface. Round-robin arbitration, one
//  transaction in flight. Sits between the CPU-side masters and the cache slave.
//  Bidirectional addr/data are split into separate in/out buses here.
// PARAMETERS
//  DATAWIDTH     8   data bus width
//  ADDRESSWIDTH  32  address bus width
//  OPWIDTH       4   operation field width (cachepkg inst_t encoding, passed through unchanged)
// PORTS
//  clock          in   1    single clock, all logic on rising edge
//  reset          in   1    synchronous, active-high
//  reqN_request   in   1    N=0,1: requester 4-phase request
//  reqN_operation in   OPW  N=0,1: operation, stable while reqN_request=1
//  reqN_addr      in   AW   N=0,1: address, stable while reqN_request=1
//  reqN_wdata     in   DW   N=0,1: write data, stable while reqN_request=1
//  reqN_valid     out  1    N=0,1: completion, 4-phase
//  reqN_evict     out  1    N=0,1: cache evicted a line for this transaction
//  reqN_rdata     out  DW   N=0,1: read data, valid while reqN_valid=1
//  cache_request  out  1    request to cache slave
//  cache_operation out OPW  latched operation of granted requester
//  cache_addr     out  AW   latched address
//  cache_wdata    out  DW   latched write data
//  cache_valid    in   1    cache completion
//  cache_evict    in   1    cache eviction flag, sampled with cache_valid
//  cache_rdata    in   DW   cache read data, sampled with cache_valid
//  busy           out  1    1 whenever state != IDLE
//  grant_id       out  1    index of current/last granted requester
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, all valid/evict/request/busy=0, buses=0,
//    grant_id=0, last_grant=1 (port 0 wins the first contention). Reset aborts any
//    transaction immediately; cache_request drops the cycle after reset is sampled.
//  - IDLE: if any reqN_request=1 pick winner: one requester -> it; both -> port != last_grant.
//    Latch winner's operation/addr/wdata into cache_* regs, set grant_id, busy=1 -> REQ.
//  - REQ: cache_request=1, cache_* held stable. On cache_valid=1: capture cache_rdata into
//    reqG_rdata, cache_evict into reqG_evict, set reqG_valid=1, cache_request=0 -> RELEASE.
//  - RELEASE: wait until cache_valid=0 AND reqG_request=0 (same cycle or any order);
//    then reqG_valid=0, reqG_evict=0, last_grant=G, busy=0 -> IDLE. rdata holds last value.
//  - Latency: request sampled at cycle t -> cache_request=1 at t+1; cache_valid sampled at
//    cycle u -> reqG_valid=1 and cache_request=0 at u+1. Min turnaround IDLE->IDLE 4 cycles.
//  - No new grant is issued before IDLE; a requester raising request while another is
//    served waits; its inputs are not sampled until granted.
//  - Requester dropping request before valid (protocol violation): transaction still runs
//    to completion; valid pulses for one cycle once cache_valid is low in RELEASE.
//  - Non-granted requester outputs (valid/evict) are always 0; rdata retains last value.
//  - cache_valid=1 in IDLE is ignored.
// TESTING
//  1 Reset: assert reset 2 cycles -> all valid/evict/request/busy=0, grant_id=0.
//  2 Single: req0 op=READ addr=0x100; cache_valid+rdata=0xA5 after 3 cycles -> req0_valid=1,
//    req0_rdata=0xA5, req1_valid stays 0; drop req0 -> valid low, back to IDLE.
//  3 Contention: req0 and req1 raised same cycle -> port 0 served first, grant_id=0; port 1
//    granted next, grant_id=1; cache_addr changes only in IDLE->REQ.
//  4 Fairness: both held continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
//  5 Evict: cache_evict=1 with cache_valid on port 1 write -> req1_evict=1 with req1_valid,
//    both clear together when handshake completes.
//  6 Reset mid-op: reset while in REQ -> cache_request=0 next cycle, IDLE, next contention
//    grants port 0.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache slave port between two requesters.
// One transaction in flight; 4-phase request/valid handshake on both sides.
module cache_port_arbiter #(
    parameter int DATAWIDTH    = 8,
    parameter int ADDRESSWIDTH = 32,
    parameter int OPWIDTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req0_request,
    input  logic [OPWIDTH-1:0]      req0_operation,
    input  logic [ADDRESSWIDTH-1:0] req0_addr,
    input  logic [DATAWIDTH-1:0]    req0_wdata,
    output logic                    req0_valid,
    output logic                    req0_evict,
    output logic [DATAWIDTH-1:0]    req0_rdata,
    input  logic                    req1_request,
    input  logic [OPWIDTH-1:0]      req1_operation,
    input  logic [ADDRESSWIDTH-1:0] req1_addr,
    input  logic [DATAWIDTH-1:0]    req1_wdata,
    output logic                    req1_valid,
    output logic                    req1_evict,
    output logic [DATAWIDTH-1:0]    req1_rdata,
    output logic                    cache_request,
    output logic [OPWIDTH-1:0]      cache_operation,
    output logic [ADDRESSWIDTH-1:0] cache_addr,
    output logic [DATAWIDTH-1:0]    cache_wdata,
    input  logic                    cache_valid,
    input  logic                    cache_evict,
    input  logic [DATAWIDTH-1:0]    cache_rdata,
    output logic                    busy,
    output logic                    grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_grant;
    logic                    r_last;
    logic                    r_busy;
    logic                    r_cache_request;
    logic [OPWIDTH-1:0]      r_cache_op;
    logic [ADDRESSWIDTH-1:0] r_cache_addr;
    logic [DATAWIDTH-1:0]    r_cache_wdata;
    logic [1:0]              r_valid;
    logic [1:0]              r_evict;
    logic [DATAWIDTH-1:0]    r_rdata0;
    logic [DATAWIDTH-1:0]    r_rdata1;

    logic                    w_any;
    logic                    w_pick;
    logic                    w_g_req;
    logic                    w_start;
    logic                    w_done;
    logic                    w_finish;
    logic [OPWIDTH-1:0]      w_op;
    logic [ADDRESSWIDTH-1:0] w_addr;
    logic [DATAWIDTH-1:0]    w_wdata;

    // A lone requester wins outright; on contention the port not served last wins.
    assign w_any    = req0_request | req1_request;
    assign w_pick   = (req0_request & req1_request) ? ~r_last : req1_request;
    assign w_g_req  = r_grant ? req1_request : req0_request;
    assign w_op     = w_pick ? req1_operation : req0_operation;
    assign w_addr   = w_pick ? req1_addr : req0_addr;
    assign w_wdata  = w_pick ? req1_wdata : req0_wdata;

    assign w_start  = (r_state == ST_IDLE) && w_any;
    assign w_done   = (r_state == ST_REQ) && cache_valid;
    assign w_finish = (r_state == ST_RELEASE) && !cache_valid && !w_g_req;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode from the three mutually exclusive transition events.
    always_comb begin
        w_state_nxt = r_state;
        unique case (1'b1)
            w_start:  w_state_nxt = ST_REQ;
            w_done:   w_state_nxt = ST_RELEASE;
            w_finish: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = r_state;
        endcase
    end

    // Registered datapath: latch on grant, capture on completion, clear on release.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant         <= 1'b0;
            r_last          <= 1'b1;
            r_busy          <= 1'b0;
            r_cache_request <= 1'b0;
            r_cache_op      <= '0;
            r_cache_addr    <= '0;
            r_cache_wdata   <= '0;
            r_valid         <= '0;
            r_evict         <= '0;
            r_rdata0        <= '0;
            r_rdata1        <= '0;
        end else begin
            if (w_start) begin
                r_grant         <= w_pick;
                r_cache_op      <= w_op;
                r_cache_addr    <= w_addr;
                r_cache_wdata   <= w_wdata;
                r_cache_request <= 1'b1;
                r_busy          <= 1'b1;
            end
            if (w_done) begin
                r_cache_request  <= 1'b0;
                r_valid[r_grant] <= 1'b1;
                r_evict[r_grant] <= cache_evict;
                if (r_grant) r_rdata1 <= cache_rdata;
                else         r_rdata0 <= cache_rdata;
            end
            if (w_finish) begin
                r_valid <= '0;
                r_evict <= '0;
                r_last  <= r_grant;
                r_busy  <= 1'b0;
            end
        end
    end

    assign req0_valid      = r_valid[0];
    assign req1_valid      = r_valid[1];
    assign req0_evict      = r_evict[0];
    assign req1_evict      = r_evict[1];
    assign req0_rdata      = r_rdata0;
    assign req1_rdata      = r_rdata1;
    assign cache_request   = r_cache_request;
    assign cache_operation = r_cache_op;
    assign cache_addr      = r_cache_addr;
    assign cache_wdata     = r_cache_wdata;
    assign busy            = r_busy;
    assign grant_id        = r_grant;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: vector table, directed fairness/reset
// sequences, then random traffic against a transaction-level model.
module tb_cache_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int OW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [1:0]          rq;
    logic [1:0][OW-1:0]  rop;
    logic [1:0][AW-1:0]  radr;
    logic [1:0][DW-1:0]  rwd;
    logic [1:0]          vld;
    logic [1:0]          evc;
    logic [1:0][DW-1:0]  rdt;
    logic                cache_request;
    logic [OW-1:0]       cache_operation;
    logic [AW-1:0]       cache_addr;
    logic [DW-1:0]       cache_wdata;
    logic                cache_valid;
    logic                cache_evict;
    logic [DW-1:0]       cache_rdata;
    logic                busy;
    logic                grant_id;

    cache_port_arbiter #(
        .DATAWIDTH(DW), .ADDRESSWIDTH(AW), .OPWIDTH(OW)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .req0_request   (rq[0]),
        .req0_operation (rop[0]),
        .req0_addr      (radr[0]),
        .req0_wdata     (rwd[0]),
        .req0_valid     (vld[0]),
        .req0_evict     (evc[0]),
        .req0_rdata     (rdt[0]),
        .req1_request   (rq[1]),
        .req1_operation (rop[1]),
        .req1_addr      (radr[1]),
        .req1_wdata     (rwd[1]),
        .req1_valid     (vld[1]),
        .req1_evict     (evc[1]),
        .req1_rdata     (rdt[1]),
        .cache_request  (cache_request),
        .cache_operation(cache_operation),
        .cache_addr     (cache_addr),
        .cache_wdata    (cache_wdata),
        .cache_valid    (cache_valid),
        .cache_evict    (cache_evict),
        .cache_rdata    (cache_rdata),
        .busy           (busy),
        .grant_id       (grant_id)
    );

    // in = {req0, req1, cache_valid, cache_evict}
    // exp = {cr, busy, gid, v0, v1, e0, e1, rdata0, rdata1, cache_addr}
    typedef struct {
        logic [3:0]  in;
        logic [7:0]  crd;
        logic [54:0] exp;
    } vec_t;

    vec_t tbl[21];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic [3:0] in, input logic [7:0] crd,
                                input logic [6:0] ctl, input logic [7:0] rd0,
                                input logic [7:0] rd1, input logic [31:0] adr);
        vec_t v;
        v.in  = in;
        v.crd = crd;
        v.exp = {ctl, rd0, rd1, adr};
        return v;
    endfunction

    function automatic logic [54:0] outs();
        return {cache_request, busy, grant_id, vld[0], vld[1],
                evc[0], evc[1], rdt[0], rdt[1], cache_addr};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cache_request) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int         st[2];
        int         cnt[2];
        int         done[2];
        int         cs;
        int         cdly;
        bit         m_act;
        logic       m_last;
        logic       m_gnt;
        logic [7:0] e_rd;
        logic       e_ev;
        logic       prev_cr;
        logic [1:0] prev_v;

        tbl[0]  = mk(4'b1000, 8'h00, 7'b1100000, 8'h00, 8'h00, 32'h100);
        tbl[1]  = mk(4'b1000, 8'h00, 7'b1100000, 8'h00, 8'h00, 32'h100);
        tbl[2]  = mk(4'b1000, 8'h00, 7'b1100000, 8'h00, 8'h00, 32'h100);
        tbl[3]  = mk(4'b1010, 8'hA5, 7'b0101000, 8'hA5, 8'h00, 32'h100);
        tbl[4]  = mk(4'b0000, 8'h00, 7'b0000000, 8'hA5, 8'h00, 32'h100);
        tbl[5]  = mk(4'b0000, 8'h00, 7'b0000000, 8'hA5, 8'h00, 32'h100);
        tbl[6]  = mk(4'b0100, 8'h00, 7'b1110000, 8'hA5, 8'h00, 32'h200);
        tbl[7]  = mk(4'b0111, 8'h5A, 7'b0110101, 8'hA5, 8'h5A, 32'h200);
        tbl[8]  = mk(4'b0100, 8'h00, 7'b0110101, 8'hA5, 8'h5A, 32'h200);
        tbl[9]  = mk(4'b0010, 8'h00, 7'b0110101, 8'hA5, 8'h5A, 32'h200);
        tbl[10] = mk(4'b0000, 8'h00, 7'b0010000, 8'hA5, 8'h5A, 32'h200);
        tbl[11] = mk(4'b1000, 8'h00, 7'b1100000, 8'hA5, 8'h5A, 32'h100);
        tbl[12] = mk(4'b0000, 8'h00, 7'b1100000, 8'hA5, 8'h5A, 32'h100);
        tbl[13] = mk(4'b0010, 8'h77, 7'b0101000, 8'h77, 8'h5A, 32'h100);
        tbl[14] = mk(4'b0000, 8'h00, 7'b0000000, 8'h77, 8'h5A, 32'h100);
        tbl[15] = mk(4'b0011, 8'hEE, 7'b0000000, 8'h77, 8'h5A, 32'h100);
        tbl[16] = mk(4'b0000, 8'h00, 7'b0000000, 8'h77, 8'h5A, 32'h100);
        tbl[17] = mk(4'b1100, 8'h00, 7'b1110000, 8'h77, 8'h5A, 32'h200);
        tbl[18] = mk(4'b1110, 8'h42, 7'b0110100, 8'h77, 8'h42, 32'h200);
        tbl[19] = mk(4'b1000, 8'h00, 7'b0010000, 8'h77, 8'h42, 32'h200);
        tbl[20] = mk(4'b1000, 8'h00, 7'b1100000, 8'h77, 8'h42, 32'h100);

        reset       = 1'b1;
        rq          = '0;
        rop[0]      = 4'h1;
        radr[0]     = 32'h100;
        rwd[0]      = 8'h11;
        rop[1]      = 4'h2;
        radr[1]     = 32'h200;
        rwd[1]      = 8'h3C;
        cache_valid = 1'b0;
        cache_evict = 1'b0;
        cache_rdata = '0;

        // Two cycles of reset, then everything must read back as zero.
        tick();
        tick();
        chk("reset_state", outs(), 55'd0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            {rq[0], rq[1], cache_valid, cache_evict} = tbl[i].in;
            cache_rdata = tbl[i].crd;
            tick();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Port 0 is now in REQ; reset aborts it immediately.
        cache_valid = 1'b0;
        cache_evict = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_mid", {cache_request, busy, grant_id, vld}, 5'd0);
        reset = 1'b0;
        rq    = 2'b11;

        // Both requesters kept busy: grants must alternate from port 0.
        for (int k = 0; k < 6; k++) begin
            int         g;
            bit         ok;
            logic [1:0] ev;
            g  = k % 2;
            ev = 2'b01 << g;
            wait_cr(ok);
            chk("fair_wait", ok, 1);
            chk($sformatf("fair_gnt%0d", k), grant_id, g);
            chk("fair_req", {cache_operation, cache_addr, cache_wdata},
                {rop[g], radr[g], rwd[g]});
            repeat (2) begin
                tick();
                chk("fair_hold", {cache_request, cache_addr}, {1'b1, radr[g]});
            end
            cache_valid = 1'b1;
            cache_rdata = 8'(8'hC0 + k);
            tick();
            chk("fair_valid", {vld, rdt[g]}, {ev, 8'(8'hC0 + k)});
            cache_valid = 1'b0;
            rq[g] = 1'b0;
            tick();
            chk("fair_idle", {busy, vld, cache_addr}, {1'b0, 2'b00, radr[g]});
            rq[g] = 1'b1;
        end

        // Random traffic against a transaction-level model.
        rq      = '0;
        reset   = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        st      = '{0, 0};
        cnt     = '{0, 3};
        done    = '{0, 0};
        cs      = 0;
        cdly    = 0;
        m_act   = 1'b0;
        m_last  = 1'b1;
        m_gnt   = 1'b0;
        e_rd    = '0;
        e_ev    = 1'b0;
        prev_cr = 1'b0;
        prev_v  = 2'b00;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (cache_request && !prev_cr) begin
                chk("rnd_overlap", m_act, 0);
                m_gnt = (rq == 2'b11) ? ~m_last : rq[1];
                chk("rnd_gnt", grant_id, m_gnt);
                chk("rnd_req", {cache_operation, cache_addr, cache_wdata},
                    {rop[m_gnt], radr[m_gnt], rwd[m_gnt]});
                m_act = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (vld[p] && !prev_v[p]) begin
                    chk("rnd_vport", p, m_gnt);
                    chk("rnd_data", {evc[p], rdt[p]}, {e_ev, e_rd});
                    done[p]++;
                end
                if (!vld[p] && prev_v[p]) begin
                    m_last = p[0];
                    m_act  = 1'b0;
                end
            end
            chk("rnd_busy", busy, m_act);
            prev_cr = cache_request;
            prev_v  = vld;

            case (cs)
                0: if (cache_request) begin
                    cdly = $urandom_range(0, 3);
                    cs   = 1;
                end
                1: if (cdly == 0) begin
                    e_rd        = 8'($urandom);
                    e_ev        = 1'($urandom);
                    cache_rdata = e_rd;
                    cache_evict = e_ev;
                    cache_valid = 1'b1;
                    cs          = 2;
                end else begin
                    cdly--;
                end
                default: if (!cache_request && $urandom_range(0, 1) == 1) begin
                    cache_valid = 1'b0;
                    cs          = 0;
                end
            endcase

            for (int p = 0; p < 2; p++) begin
                case (st[p])
                    0: if (cnt[p] == 0) begin
                        rop[p]  = 4'($urandom);
                        radr[p] = $urandom;
                        rwd[p]  = 8'($urandom);
                        rq[p]   = 1'b1;
                        st[p]   = 1;
                    end else begin
                        cnt[p]--;
                    end
                    1: if (vld[p] && $urandom_range(0, 2) != 0) begin
                        rq[p] = 1'b0;
                        st[p] = 2;
                    end
                    default: if (!vld[p]) begin
                        cnt[p] = $urandom_range(0, 4);
                        st[p]  = 0;
                    end
                endcase
            end
        end

        chk("rnd_prog0", done[0] >= 20, 1);
        chk("rnd_prog1", done[1] >= 20, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
